// File: rtl/hmmm_pgrm_loader.sv
// hmmm_pgrm_loader: deserializes the two-pin program-load stream into 8-bit address /
// 16-bit instruction frames and writes each one to instruction memory with req/gnt.
module hmmm_pgrm_loader #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pgrm_addr,
    input  logic        pgrm_data,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        core_hold,
    output logic        overrun,
    output logic [7:0]  frame_cnt
);
    localparam int IW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] addr_sync_q, addr_sync_d, data_sync_q, data_sync_d;
    logic                   addr_prev_q, addr_prev_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [23:0]            sh_q, sh_d;
    logic [7:0]             mem_addr_q, mem_addr_d;
    logic [15:0]            mem_wdata_q, mem_wdata_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;

    logic        addr_s, data_s, rise, tmo, last, pending, stall, load, grant, tmo_clr;
    logic [23:0] frame;

    always_comb begin
        addr_s      = addr_sync_q[SYNC_STAGES-1];
        data_s      = data_sync_q[SYNC_STAGES-1];
        addr_sync_d = {addr_sync_q[SYNC_STAGES-2:0], pgrm_addr};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], pgrm_data};
        addr_prev_d = addr_s;
        rise        = addr_s && !addr_prev_q;
        // A rise implies addr_s high, so a rise on the threshold cycle always wins.
        tmo         = !addr_s && (idle_q >= IW'(TIMEOUT - 1));
        idle_d      = addr_s ? '0 : (tmo ? idle_q : idle_q + 1'b1);
        frame       = {sh_q[22:0], data_s};
        last        = rise && (cnt_q == 5'd23);
        pending     = (state_q == WRITE);
        stall       = pending && !mem_gnt;
        grant       = pending && mem_gnt;
        load        = last && !stall;
        tmo_clr     = tmo && (state_q == SHIFT);
        cnt_d       = rise ? (last ? 5'd0 : cnt_q + 5'd1) : (tmo_clr ? 5'd0 : cnt_q);
        sh_d        = rise ? frame : (tmo_clr ? 24'd0 : sh_q);
        state_d     = (load || stall) ? WRITE : ((cnt_d != 5'd0) ? SHIFT : IDLE);
        mem_addr_d  = load ? frame[23:16] : mem_addr_q;
        mem_wdata_d = load ? frame[15:0] : mem_wdata_q;
        overrun_d   = overrun_q || (last && stall);
        frame_cnt_d = frame_cnt_q + {7'd0, grant};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_sync_q <= '0;
            data_sync_q <= '0;
            addr_prev_q <= 1'b0;
            idle_q      <= '0;
            cnt_q       <= '0;
            sh_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_sync_q <= addr_sync_d;
            data_sync_q <= data_sync_d;
            addr_prev_q <= addr_prev_d;
            idle_q      <= idle_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign mem_req   = (state_q == WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = (state_q != IDLE) || (cnt_q != 5'd0);
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_hmmm_pgrm_loader.sv
// tb_hmmm_pgrm_loader: scoreboard bench; expected frames are queued as they are sent
// and compared on every granted memory write.
module tb_hmmm_pgrm_loader;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst, pgrm_addr, pgrm_data, mem_gnt;
    logic        mem_req, core_hold, overrun;
    logic [7:0]  mem_addr, frame_cnt;
    logic [15:0] mem_wdata;

    logic [23:0] sb[$];
    logic [23:0] exp_f;
    int          n_cmp = 0, n_bad = 0, req_cycles = 0, req0;
    logic [15:0] rnd;

    hmmm_pgrm_loader #(.SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pgrm_addr(pgrm_addr), .pgrm_data(pgrm_data),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        pgrm_data = b;
        repeat (3) @(negedge clk);
        pgrm_addr = 1'b1;
        repeat (3) @(negedge clk);
        pgrm_addr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [15:0] d);
        logic [23:0] f;
        f = {a, d};
        for (int i = 23; i >= 0; i--) send_bit(f[i]);
        repeat (4) @(negedge clk);
    endtask

    // Write monitor: samples between edges, after the stimulus for the next edge is set.
    always @(negedge clk) begin
        #2;
        if (rst && mem_req) begin
            req_cycles++;
            if (mem_gnt) begin
                if (sb.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
                else begin
                    exp_f = sb.pop_front();
                    chk("wr_frame", 32'({mem_addr, mem_wdata}), 32'(exp_f));
                end
            end
        end
    end

    initial begin
        rst = 1'b0; pgrm_addr = 1'b0; pgrm_data = 1'b0; mem_gnt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_hold", 32'(core_hold), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        mem_gnt = 1'b1;
        req0 = req_cycles;
        sb.push_back({8'h05, 16'h1A2B});
        fork
            send_frame(8'h05, 16'h1A2B);
            begin repeat (10) @(negedge clk); #1 chk("hold_busy", 32'(core_hold), 1); end
        join
        repeat (5) @(negedge clk);
        chk("req_pulses", 32'(req_cycles - req0), 1);
        chk("cnt_single", 32'(frame_cnt), 1);
        chk("hold_after", 32'(core_hold), 0);
        chk("sb_single", 32'(sb.size()), 0);

        mem_gnt = 1'b0;
        sb.push_back({8'h01, 16'h1234});
        send_frame(8'h01, 16'h1234);
        sb.push_back({8'h06, 16'hBEEF});
        fork
            send_frame(8'h06, 16'hBEEF);
            begin
                repeat (40) @(negedge clk);
                chk("held_req", 32'(mem_req), 1);
                chk("held_addr", 32'(mem_addr), 32'h01);
                chk("held_data", 32'(mem_wdata), 32'h1234);
                mem_gnt = 1'b1;
            end
        join
        repeat (5) @(negedge clk);
        chk("cnt_delayed", 32'(frame_cnt), 3);
        chk("ovr_delayed", 32'(overrun), 0);
        chk("sb_delayed", 32'(sb.size()), 0);

        mem_gnt = 1'b0;
        sb.push_back({8'h10, 16'hAAAA});
        send_frame(8'h10, 16'hAAAA);
        send_frame(8'h11, 16'h5555);
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_addr", 32'(mem_addr), 32'h10);
        chk("ovr_data", 32'(mem_wdata), 32'hAAAA);
        mem_gnt = 1'b1;
        repeat (5) @(negedge clk);
        chk("cnt_ovr", 32'(frame_cnt), 4);
        chk("req_ovr", 32'(mem_req), 0);
        chk("sb_ovr", 32'(sb.size()), 0);

        for (int i = 0; i < 10; i++) send_bit(i[0]);
        repeat (2) @(negedge clk);
        chk("hold_partial", 32'(core_hold), 1);
        repeat (TMO + 5) @(negedge clk);
        chk("hold_tmo", 32'(core_hold), 0);
        sb.push_back({8'hFF, 16'h0000});
        send_frame(8'hFF, 16'h0000);
        repeat (3) @(negedge clk);
        chk("cnt_tmo", 32'(frame_cnt), 5);
        chk("sb_tmo", 32'(sb.size()), 0);

        for (int i = 0; i < 12; i++) send_bit(1'b1);
        chk("hold_mid", 32'(core_hold), 1);
        rst = 1'b0;
        #1;
        chk("mid_req", 32'(mem_req), 0);
        chk("mid_addr", 32'(mem_addr), 0);
        chk("mid_wdata", 32'(mem_wdata), 0);
        chk("mid_hold", 32'(core_hold), 0);
        chk("mid_ovr", 32'(overrun), 0);
        chk("mid_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_rel_hold", 32'(core_hold), 0);

        mem_gnt = 1'b0;
        send_frame(8'h22, 16'h3333);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        chk("wr_pending", 32'(mem_req), 1);
        rst = 1'b0;
        #1;
        chk("wr_rst_req", 32'(mem_req), 0);
        chk("wr_rst_addr", 32'(mem_addr), 0);
        chk("wr_rst_wdata", 32'(mem_wdata), 0);
        chk("wr_rst_hold", 32'(core_hold), 0);
        @(negedge clk);
        rst = 1'b1;
        mem_gnt = 1'b1;
        repeat (20) @(negedge clk);
        chk("wr_rel_cnt", 32'(frame_cnt), 0);
        chk("wr_rel_req", 32'(mem_req), 0);

        for (int i = 0; i < 256; i++) begin
            rnd = 16'($urandom);
            sb.push_back({8'(i), rnd});
            send_frame(8'(i), rnd);
            if (i == 127) chk("cnt_half", 32'(frame_cnt), 128);
        end
        repeat (5) @(negedge clk);
        chk("cnt_wrap", 32'(frame_cnt), 0);
        chk("sb_wrap", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
